ps2_rx_evfifo: RTL and testbench

- Parametrised PS/2 receiver, successor to the fixed 8-deep keyboard receiver.
- Features: input synchronisers, frame checking with sticky error flags, mid-frame watchdog timeout, optional scan-code event decoding, power-of-2 FIFO with a valid/ready read port.
- Sits between the PS/2 pins and the keyboard processing/ASCII logic.
- Replaces the nextdata_n strobe with a standard handshake.

---
 rtl/ps2_rx_evfifo.sv | 152 +++++++++++++++
 tb/tb_ps2_rx_evfifo.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_evfifo.sv
// rtl/ps2_rx_evfifo.sv - PS/2 receiver with frame checks, watchdog, scan-code event decode and FIFO
module ps2_rx_evfifo #(
  parameter int DEPTH       = 8,
  parameter int MODE        = 0,
  parameter int TIMEOUT_CYC = 25000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ps2_clk,
  input  logic                   ps2_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [9:0]             rd_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   parity_err,
  output logic                   frame_err,
  input  logic                   err_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]    clk_sync_q;
  logic [1:0]    dat_sync_q;
  logic [3:0]    cnt_q, cnt_d;
  logic [8:0]    sr_q, sr_d;
  logic [TW-1:0] to_q, to_d;
  logic          byte_vld_q, byte_vld_d;
  logic [7:0]    byte_q, byte_d;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic [AW:0]   wptr_q, rptr_q;
  logic          ovf_q, par_q, frm_q;
  logic [9:0]    mem_q [DEPTH];

  logic       fall, dat_bit, par_set, frm_set;
  logic       is_pfx, push_req, push_ok, pop, full, empty;
  logic [9:0] entry;

  assign fall    = clk_sync_q[2] & ~clk_sync_q[1];
  assign dat_bit = dat_sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
    end
  end

  // Frame capture: data and parity shift in LSB first; the stop bit is judged without being stored.
  always_comb begin
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    to_d       = to_q;
    byte_vld_d = 1'b0;
    byte_d     = byte_q;
    par_set    = 1'b0;
    frm_set    = 1'b0;
    if (fall) begin
      to_d = '0;
      if (cnt_q == 4'd0) begin
        if (!dat_bit) cnt_d = 4'd1;
      end else if (cnt_q == 4'd10) begin
        cnt_d = 4'd0;
        if (!dat_bit)           frm_set = 1'b1;
        else if (^sr_q == 1'b0) par_set = 1'b1;
        else begin
          byte_vld_d = 1'b1;
          byte_d     = sr_q[7:0];
        end
      end else begin
        sr_d  = {dat_bit, sr_q[8:1]};
        cnt_d = cnt_q + 4'd1;
      end
    end else if (cnt_q != 4'd0) begin
      if (to_q == TW'(TIMEOUT_CYC - 1)) begin
        cnt_d   = 4'd0;
        to_d    = '0;
        frm_set = 1'b1;
      end else begin
        to_d = to_q + 1'b1;
      end
    end else begin
      to_d = '0;
    end
  end

  always_comb begin
    is_pfx   = (MODE == 0) && ((byte_q == 8'hE0) || (byte_q == 8'hF0));
    push_req = byte_vld_q & ~is_pfx;
    entry    = (MODE == 0) ? {ext_q, brk_q, byte_q} : {2'b00, byte_q};
    ext_d    = ext_q;
    brk_d    = brk_q;
    if (byte_vld_q && (MODE == 0)) begin
      if (byte_q == 8'hE0)      ext_d = 1'b1;
      else if (byte_q == 8'hF0) brk_d = 1'b1;
      else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rd_valid = ~empty;
  assign pop      = rd_valid & rd_ready;
  assign push_ok  = push_req & (~full | pop);
  // Gated so an empty FIFO presents zero rather than a stale entry.
  assign rd_data  = rd_valid ? mem_q[rptr_q[AW-1:0]] : 10'd0;
  assign level    = wptr_q - rptr_q;

  assign overflow   = ovf_q;
  assign parity_err = par_q;
  assign frame_err  = frm_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      sr_q       <= '0;
      to_q       <= '0;
      byte_vld_q <= 1'b0;
      byte_q     <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      ovf_q      <= 1'b0;
      par_q      <= 1'b0;
      frm_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      to_q       <= to_d;
      byte_vld_q <= byte_vld_d;
      byte_q     <= byte_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      ovf_q      <= (ovf_q & ~err_clr) | (push_req & ~push_ok);
      par_q      <= (par_q & ~err_clr) | par_set;
      frm_q      <= (frm_q & ~err_clr) | frm_set;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wptr_q[AW-1:0]] <= entry;
  end
endmodule

// File: tb/tb_ps2_rx_evfifo.sv
// tb/tb_ps2_rx_evfifo.sv - directed bench for ps2_rx_evfifo in event and raw modes
module tb_ps2_rx_evfifo;
  localparam int HP = 20;

  logic clk = 1'b0;
  logic rst, ps2_clk, ps2_data, err_clr;
  logic rd_ready0, rd_ready1;
  logic rd_valid0, rd_valid1;
  logic [9:0] rd_data0, rd_data1;
  logic [2:0] level0;
  logic [3:0] level1;
  logic ovf0, ovf1, perr0, perr1, ferr0, ferr1;
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ps2_rx_evfifo #(.DEPTH(4), .MODE(0), .TIMEOUT_CYC(200)) u0 (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_valid(rd_valid0), .rd_ready(rd_ready0), .rd_data(rd_data0), .level(level0),
    .overflow(ovf0), .parity_err(perr0), .frame_err(ferr0), .err_clr(err_clr)
  );

  ps2_rx_evfifo #(.DEPTH(8), .MODE(1), .TIMEOUT_CYC(200)) u1 (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_valid(rd_valid1), .rd_ready(rd_ready1), .rd_data(rd_data1), .level(level1),
    .overflow(ovf1), .parity_err(perr1), .frame_err(ferr1), .err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [10:0] frm(input logic [7:0] b, input logic badpar);
    return {1'b1, (~^b) ^ badpar, b, 1'b0};
  endfunction

  // Drives frame bits lo..hi; pop_at_push raises u0 rd_ready during the push cycle of the stop bit.
  task automatic send_bits(input logic [10:0] f, input int lo, input int hi, input logic pop_at_push);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      repeat (HP) @(negedge clk);
      ps2_clk = 1'b0;
      if (pop_at_push && i == 10) begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t4_head_at_push", rd_data0, 10'h016);
        rd_ready0 = 1'b1;
        @(negedge clk);
        rd_ready0 = 1'b0;
        repeat (HP - 5) @(negedge clk);
      end else begin
        repeat (HP) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (HP) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_bits(frm(b, 1'b0), 0, 10, 1'b0);
  endtask

  task automatic pop0(input string tag, input logic [9:0] exp);
    @(negedge clk);
    chk({tag, "_valid"}, rd_valid0, 1);
    chk(tag, rd_data0, exp);
    rd_ready0 = 1'b1;
    @(negedge clk);
    rd_ready0 = 1'b0;
  endtask

  task automatic pop1(input string tag, input logic [9:0] exp);
    @(negedge clk);
    chk({tag, "_valid"}, rd_valid1, 1);
    chk(tag, rd_data1, exp);
    rd_ready1 = 1'b1;
    @(negedge clk);
    rd_ready1 = 1'b0;
  endtask

  task automatic clear_errs();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; err_clr = 1'b0;
    rd_ready0 = 1'b0; rd_ready1 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", rd_valid0, 0);
    chk("rst_level", level0, 0);
    chk("rst_flags", {ovf0, perr0, ferr0}, 0);

    // 1: break prefix folds into the following code
    send(8'h1C); send(8'hF0); send(8'h1C);
    @(negedge clk);
    chk("t1_level", level0, 2);
    pop0("t1_pop0", 10'h01C);
    pop0("t1_pop1", 10'h11C);
    chk("t1_level_end", level0, 0);
    chk("t1_valid_end", rd_valid0, 0);

    // 2: extended and extended-break
    send(8'hE0); send(8'hF0); send(8'h75); send(8'hE0); send(8'h75);
    @(negedge clk);
    chk("t2_level", level0, 2);
    pop0("t2_pop0", 10'h375);
    pop0("t2_pop1", 10'h275);

    // 3: parity error
    send_bits(frm(8'h1C, 1'b1), 0, 10, 1'b0);
    @(negedge clk);
    chk("t3_perr", perr0, 1);
    chk("t3_level", level0, 0);
    send(8'h32);
    pop0("t3_pop", 10'h032);
    clear_errs();
    chk("t3_perr_clr", perr0, 0);

    // 4: overflow with DEPTH=4, then simultaneous push/pop while full
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25); send(8'h2E);
    @(negedge clk);
    chk("t4_level_full", level0, 4);
    chk("t4_ovf", ovf0, 1);
    pop0("t4_pop0", 10'h016);
    pop0("t4_pop1", 10'h01E);
    pop0("t4_pop2", 10'h026);
    pop0("t4_pop3", 10'h025);
    chk("t4_level_empty", level0, 0);
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
    @(negedge clk);
    chk("t4_refill", level0, 4);
    send_bits(frm(8'h29, 1'b0), 0, 10, 1'b1);
    @(negedge clk);
    chk("t4_level_pp", level0, 4);
    chk("t4_ovf_keep", ovf0, 1);
    pop0("t4_pp0", 10'h01E);
    pop0("t4_pp1", 10'h026);
    pop0("t4_pp2", 10'h025);
    pop0("t4_pp3", 10'h029);

    // 5: mid-frame watchdog
    clear_errs();
    chk("t5_flags_clr", {ovf0, perr0, ferr0}, 0);
    send_bits(frm(8'h29, 1'b0), 0, 3, 1'b0);
    repeat (250) @(negedge clk);
    chk("t5_ferr", ferr0, 1);
    chk("t5_level", level0, 0);
    send(8'h29);
    pop0("t5_pop", 10'h029);

    // 6: raw mode, then reset mid-frame
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    send(8'hE0); send(8'hF0); send(8'h75);
    pop1("t6_pop0", 10'h0E0);
    pop1("t6_pop1", 10'h0F0);
    pop1("t6_pop2", 10'h075);
    send_bits(frm(8'h5A, 1'b0), 0, 5, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("t6_rst_outs", {rd_valid1, rd_data1, level1, ovf1, perr1, ferr1}, 0);
    send_bits(frm(8'h5A, 1'b0), 6, 10, 1'b0);
    repeat (250) @(negedge clk);
    chk("t6_tail_level", level1, 0);
    chk("t6_tail_valid", rd_valid1, 0);
    chk("t6_tail_ferr", ferr1, 1);
    send(8'h45);
    pop1("t6_pop45", 10'h045);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
